// File: rtl/scp_pkg.sv
// Shared encodings for the scp_079 / facility alert loop: FSM state codes and
// one-hot alert colours {green,yellow,red}.
package scp_pkg;

    typedef enum logic [2:0] {
        GREEN    = 3'd0,
        YELLOW   = 3'd1,
        RED      = 3'd2,
        LOCKDOWN = 3'd3,
        RECOVER  = 3'd4
    } alert_state_t;

    localparam logic [2:0] COL_GREEN  = 3'b100;
    localparam logic [2:0] COL_YELLOW = 3'b010;
    localparam logic [2:0] COL_RED    = 3'b001;

    function automatic logic [2:0] state_colour(input alert_state_t s);
        case (s)
            YELLOW, RECOVER: state_colour = COL_YELLOW;
            RED, LOCKDOWN:   state_colour = COL_RED;
            default:         state_colour = COL_GREEN;
        endcase
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear and saturating increment; it never wraps.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clock) begin
        if (reset || clear)
            count <= '0;
        else if (inc && (count != {W{1'b1}}))
            count <= count + 1'b1;
    end

endmodule

// File: rtl/facility_alert_ctrl.sv
// Facility alert FSM: watches scp_079 attack flags and drives the one-hot
// green/yellow/red level back to it, with escalation and cool-down timers.
module facility_alert_ctrl
    import scp_pkg::*;
#(
    parameter int TIMER_W        = 8,
    parameter int ESC_CYCLES     = 3,
    parameter int CALM_CYCLES    = 5,
    parameter int YELLOW_MAX     = 10,
    parameter int RED_MIN        = 12,
    parameter int LOCK_CYCLES    = 20,
    parameter int RECOVER_CYCLES = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               a_security,
    input  logic               a_database,
    input  logic               a_control_sys,
    input  logic               cheat_out,
    output logic               green,
    output logic               yellow,
    output logic               red,
    output logic [2:0]         alert_state,
    output logic [TIMER_W-1:0] timer
);

    localparam logic [TIMER_W-1:0] ESC_LAST     = TIMER_W'(ESC_CYCLES - 1);
    localparam logic [TIMER_W-1:0] CALM_LAST    = TIMER_W'(CALM_CYCLES - 1);
    localparam logic [TIMER_W-1:0] YELLOW_LAST  = TIMER_W'(YELLOW_MAX - 1);
    localparam logic [TIMER_W-1:0] RED_LAST     = TIMER_W'(RED_MIN - 1);
    localparam logic [TIMER_W-1:0] LOCK_LAST    = TIMER_W'(LOCK_CYCLES - 1);
    localparam logic [TIMER_W-1:0] RECOVER_LAST = TIMER_W'(RECOVER_CYCLES - 1);

    alert_state_t       state, state_next;
    logic [2:0]         colour;
    logic [TIMER_W-1:0] atk_streak, quiet_streak;
    logic               any_atk, severe, state_chg;

    assign any_atk = a_security | a_database | a_control_sys;
    // Control-system compromise alone is severe; otherwise any two of three.
    assign severe  = a_control_sys | (a_security & a_database);

    always_comb begin
        state_next = state;
        case (state)
            GREEN: begin
                if (cheat_out)                           state_next = LOCKDOWN;
                else if (severe)                         state_next = RED;
                else if (any_atk && atk_streak == ESC_LAST) state_next = YELLOW;
            end
            YELLOW: begin
                if (cheat_out)                           state_next = LOCKDOWN;
                else if (severe)                         state_next = RED;
                else if (any_atk && timer == YELLOW_LAST) state_next = RED;
                else if (!any_atk && quiet_streak == CALM_LAST) state_next = GREEN;
            end
            RED: begin
                if (cheat_out)                           state_next = LOCKDOWN;
                else if (timer >= RED_LAST && !any_atk)  state_next = RECOVER;
            end
            LOCKDOWN: begin
                // Deliberately deaf to every input, cheat_out included.
                if (timer == LOCK_LAST)                  state_next = RECOVER;
            end
            RECOVER: begin
                if (cheat_out)                           state_next = LOCKDOWN;
                else if (any_atk)                        state_next = RED;
                else if (quiet_streak == RECOVER_LAST)   state_next = GREEN;
            end
            default:                                     state_next = GREEN;
        endcase
    end

    assign state_chg = (state_next != state);

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= GREEN;
            colour <= COL_GREEN;
        end else begin
            state  <= state_next;
            colour <= state_colour(state_next);
        end
    end

    sat_counter #(.W(TIMER_W)) u_timer (
        .clock (clock),
        .reset (reset),
        .clear (state_chg),
        .inc   (1'b1),
        .count (timer)
    );

    sat_counter #(.W(TIMER_W)) u_atk_streak (
        .clock (clock),
        .reset (reset),
        .clear (state_chg | ~any_atk),
        .inc   (any_atk),
        .count (atk_streak)
    );

    sat_counter #(.W(TIMER_W)) u_quiet_streak (
        .clock (clock),
        .reset (reset),
        .clear (state_chg | any_atk),
        .inc   (~any_atk),
        .count (quiet_streak)
    );

    assign {green, yellow, red} = colour;
    assign alert_state          = state;

endmodule

// File: tb/tb_facility_alert_ctrl.sv
// Scoreboard bench: a driver pushes the reference model's expected post-edge
// view per cycle; a monitor pops and compares after every rising edge.
module tb_facility_alert_ctrl;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       a_security = 1'b0, a_database = 1'b0, a_control_sys = 1'b0, cheat_out = 1'b0;
    logic       green, yellow, red;
    logic [2:0] alert_state;
    logic [7:0] timer;

    facility_alert_ctrl dut (
        .clock         (clock),
        .reset         (reset),
        .a_security    (a_security),
        .a_database    (a_database),
        .a_control_sys (a_control_sys),
        .cheat_out     (cheat_out),
        .green         (green),
        .yellow        (yellow),
        .red           (red),
        .alert_state   (alert_state),
        .timer         (timer)
    );

    always #5 clock = ~clock;

    typedef struct {
        int st;
        int col;
        int tmr;
    } exp_t;

    exp_t q[$];
    int   checks = 0, errors = 0;
    bit   started = 1'b0;

    // Reference model: time in state and run lengths of attack/quiet samples.
    int m_state = 0, m_time = 0, m_atk = 0, m_quiet = 0;

    function automatic int colour_of(input int s);
        if (s == 0) return 4;
        if (s == 1 || s == 4) return 2;
        return 1;
    endfunction

    task automatic model_step(input bit r, input bit s, input bit d, input bit c, input bit ch);
        int  nxt, na, nq, in_state, hits;
        bit  any, sev;
        if (r) begin
            m_state = 0; m_time = 0; m_atk = 0; m_quiet = 0;
            return;
        end
        hits     = int'(s) + int'(d) + int'(c);
        any      = hits > 0;
        sev      = c || hits >= 2;
        na       = any ? m_atk + 1 : 0;
        nq       = any ? 0 : m_quiet + 1;
        in_state = m_time + 1;
        nxt      = m_state;
        if (m_state == 3) begin
            if (in_state >= 20) nxt = 4;
        end else if (ch) begin
            nxt = 3;
        end else begin
            case (m_state)
                0: if (sev) nxt = 2; else if (na >= 3) nxt = 1;
                1: if (sev) nxt = 2; else if (any && in_state == 10) nxt = 2;
                   else if (nq >= 5) nxt = 0;
                2: if (in_state >= 12 && !any) nxt = 4;
                4: if (any) nxt = 2; else if (nq >= 8) nxt = 0;
                default: nxt = 0;
            endcase
        end
        if (nxt != m_state) begin
            m_state = nxt; m_time = 0; m_atk = 0; m_quiet = 0;
        end else begin
            m_time  = (m_time < 255) ? m_time + 1 : 255;
            m_atk   = na;
            m_quiet = nq;
        end
    endtask

    task automatic cyc(input bit r, input bit s, input bit d, input bit c, input bit ch);
        exp_t e;
        @(negedge clock);
        reset = r; a_security = s; a_database = d; a_control_sys = c; cheat_out = ch;
        model_step(r, s, d, c, ch);
        e.st = m_state; e.col = colour_of(m_state); e.tmr = m_time;
        q.push_back(e);
        started = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(0, 0, 0, 0, 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (int'(alert_state) != e.st) begin
                    errors++;
                    $display("FAIL state t=%0t got=%0d exp=%0d", $time, alert_state, e.st);
                end
                checks++;
                if (int'({green, yellow, red}) != e.col) begin
                    errors++;
                    $display("FAIL colour t=%0t got=%b exp=%03b", $time, {green, yellow, red}, e.col[2:0]);
                end
                checks++;
                if (int'(timer) != e.tmr) begin
                    errors++;
                    $display("FAIL timer t=%0t got=%0d exp=%0d", $time, timer, e.tmr);
                end
            end else if (started) begin
                checks++;
                errors++;
                $display("FAIL scoreboard t=%0t got=empty exp=entry", $time);
            end
        end
    end

    initial begin : driver
        int bias;
        repeat (2) cyc(1, 0, 0, 0, 0);
        idle(10);
        // escalate then calm down, then a gapped pattern that must not escalate
        repeat (3) cyc(0, 1, 0, 0, 0);
        idle(5);
        cyc(0, 1, 0, 0, 0); cyc(0, 1, 0, 0, 0); cyc(0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0); cyc(0, 1, 0, 0, 0);
        idle(2);
        // YELLOW under attack -> RED, minimum dwell, RECOVER -> GREEN
        repeat (3) cyc(0, 1, 0, 0, 0);
        repeat (14) cyc(0, 0, 1, 0, 0);
        idle(16);
        // RECOVER interrupted by an attack at timer 3
        repeat (3) cyc(0, 1, 0, 0, 0);
        repeat (14) cyc(0, 0, 1, 0, 0);
        idle(11);
        cyc(0, 1, 0, 0, 0);
        idle(20);
        // lockdown ignores everything, cheat included
        cyc(0, 0, 0, 0, 1);
        repeat (19) cyc(0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        idle(10);
        // severe from GREEN, then reset mid-lockdown
        cyc(0, 0, 0, 1, 0);
        idle(15);
        cyc(0, 0, 0, 0, 1);
        idle(7);
        cyc(1, 1, 1, 1, 1);
        cyc(0, 1, 1, 0, 1);
        idle(300);
        // randomized phases with varying attack density
        for (int ph = 0; ph < 60; ph++) begin
            bias = (ph % 4 == 0) ? 0 : (ph % 4 == 1) ? 20 : (ph % 4 == 2) ? 50 : 90;
            repeat (50) cyc($urandom_range(0, 255) == 0,
                            $urandom_range(0, 99) < bias,
                            $urandom_range(0, 99) < bias,
                            $urandom_range(0, 399) < bias,
                            $urandom_range(0, 63) == 0);
        end
        @(posedge clock);
        #3;
        started = 1'b0;
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain got=%0d exp=0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/facility_alert_ctrl.md
Name: facility_alert_ctrl

Overview:
Facility-side security controller that closes the loop with the scp_079 attack FSM. It samples scp_079's attack outputs (a_security, a_database, a_control_sys, cheat_out) and drives the one-hot green/yellow/red alert level that scp_079 consumes. It is a Moore FSM with escalation and de-escalation timers, one clock cycle per simulated second, with a visible state code and timer for the bench.

Parameters:
TIMER_W, 8, width of the timer output and the internal streak counters.
ESC_CYCLES, 3, consecutive attack samples in GREEN before escalating to YELLOW.
CALM_CYCLES, 5, consecutive quiet samples in YELLOW before returning to GREEN.
YELLOW_MAX, 10, maximum cycles in YELLOW under attack before forcing RED.
RED_MIN, 12, minimum dwell in RED.
LOCK_CYCLES, 20, fixed dwell in LOCKDOWN.
RECOVER_CYCLES, 8, quiet cycles in RECOVER before returning to GREEN.

Ports:
clock  input  1  system clock; all state changes on the rising edge.
reset  input  1  synchronous, active-high reset.
a_security  input  1  security-system attack flag from scp_079.
a_database  input  1  database attack flag.
a_control_sys  input  1  control-system attack flag (severe).
cheat_out  input  1  cheat/override detected; highest priority.
green  output  1  alert level green (one-hot with yellow and red).
yellow  output  1  alert level yellow.
red  output  1  alert level red.
alert_state  output  3  state code: GREEN=0, YELLOW=1, RED=2, LOCKDOWN=3, RECOVER=4.
timer  output  TIMER_W  cycles since entry to the current state; saturates at all-ones.

Behaviour:
- Reset (sampled at the edge): alert_state=0, {green,yellow,red}=100, timer=0, streaks=0. Reset wins over all inputs, including mid-LOCKDOWN.
- Definitions: any_atk = a_security|a_database|a_control_sys. severe = a_control_sys OR at least two of the three attack lines high.
- Outputs are Moore and registered. Colours change on the same edge as the state: GREEN gives 100, YELLOW and RECOVER give 010, RED and LOCKDOWN give 001. Exactly one colour is high at all times.
- timer is 0 on the first cycle in a new state and increments each cycle the state is held. It is compared as registered, so transitions on "timer==N-1" occur after N cycles in the state.
- Streak counters: atk_streak counts consecutive any_atk samples; quiet_streak counts consecutive !any_atk samples. Both clear on every state change and when the opposite condition is sampled.
- Priority in every state except LOCKDOWN: cheat_out goes to LOCKDOWN, then the state-specific rules apply.
- GREEN: any_atk while atk_streak==ESC_CYCLES-1 goes to YELLOW, i.e. the edge of the 3rd consecutive attack sample. A gap resets the count. severe in GREEN goes directly to RED.
- YELLOW, in priority order:
  - severe goes to RED.
  - any_atk and timer==YELLOW_MAX-1 goes to RED.
  - !any_atk and quiet_streak==CALM_CYCLES-1 goes to GREEN.
  - Otherwise hold.
- RED: while timer<RED_MIN-1, hold regardless of attack inputs. After that, !any_atk goes to RECOVER; otherwise hold.
- LOCKDOWN: ignores all inputs, including cheat_out. At timer==LOCK_CYCLES-1 it goes to RECOVER.
- RECOVER: any_atk goes to RED immediately. !any_atk with quiet_streak==RECOVER_CYCLES-1 goes to GREEN.
- Unused state codes 5-7 go to GREEN on the next edge.
- Timer saturation: timer holds at 2^TIMER_W-1 and never wraps. Comparisons use parameters below that value.
- Simultaneous events: cheat_out together with severe goes to LOCKDOWN. Reset together with anything gives the reset values.

Decomposition:
- Shared package scp_pkg holds:
  - state encoding constants (GREEN..RECOVER, 3 bits);
  - alert colour constants (COL_GREEN=3'b100, COL_YELLOW=3'b010, COL_RED=3'b001), reusable by scp_079.
- One natural sub-module, sat_counter: a TIMER_W-bit counter with synchronous clear and saturating increment. It is instantiated three times, for timer, atk_streak and quiet_streak.

Test Plan:
1. Reset held 2 cycles, then all inputs 0 for 10 cycles: state 0, colours 100, timer counts 0..9.
2. a_security=1 for 3 cycles from GREEN: YELLOW (010) on the 3rd edge. Inputs 0 for 5 cycles: back to GREEN on the 5th quiet edge. Pattern 1,1,0,1,1 instead: stays GREEN.
3. In YELLOW, a_database=1 held: RED after exactly 10 cycles in YELLOW. Inputs drop at RED timer 4: RED holds until timer 11, then RECOVER (010).
4. RECOVER with 8 quiet cycles: GREEN. Repeat with a_security pulse at RECOVER timer 3: RED on that edge.
5. cheat_out=1 for 1 cycle in GREEN: LOCKDOWN (001, state 3). All attacks toggled during lockdown: no effect. RECOVER after 20 cycles.
6. a_control_sys=1 in GREEN: RED next edge. Reset asserted mid-LOCKDOWN at timer 7: GREEN, 100, timer 0 next edge.
